// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : btn_pkg
// Purpose  : Shared state encoding and 100 MHz timing defaults for button
//            conditioning blocks.
// Revision : 1.0
// ============================================================================
package btn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_WAIT = 3'd1,
    ST_HELD       = 3'd2,
    ST_REPEAT     = 3'd3,
    ST_REL_WAIT   = 3'd4
  } btn_state_e;

  // 10 ms debounce, 500 ms first repeat, 100 ms repeat period at 100 MHz
  localparam int c_DEBOUNCE_CYCLES      = 1_000_000;
  localparam int c_REPEAT_DELAY_CYCLES  = 50_000_000;
  localparam int c_REPEAT_PERIOD_CYCLES = 10_000_000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : 1-bit two-flop synchronizer for asynchronous board inputs.
// Revision : 1.0
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/button_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce_pulse
// Purpose  : Debounces a raw push button into a clean level plus one-cycle
//            press/release strobes, with optional auto-repeat while held.
// Revision : 1.0
// ============================================================================
module button_debounce_pulse
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = c_DEBOUNCE_CYCLES,
  parameter bit REPEAT_EN            = 1'b1,
  parameter int REPEAT_DELAY_CYCLES  = c_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD_CYCLES = c_REPEAT_PERIOD_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_release,
  output logic repeat_active
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES,
                                     REPEAT_PERIOD_CYCLES));
  localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_DLY_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_PER_LAST = CNT_W'(REPEAT_PERIOD_CYCLES - 1);

  logic             w_s;
  btn_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_pulse;
  logic             r_release;
  logic             r_active;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (btn_in),
    .o_q   (w_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_pulse   <= 1'b0;
      r_release <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_pulse   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_s) begin
            r_state <= ST_PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!w_s) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == c_DEB_LAST) begin
            r_state <= ST_HELD;
            r_cnt   <= '0;
            r_pulse <= 1'b1;
            r_level <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (!w_s) begin
            r_state <= ST_REL_WAIT;
            r_cnt   <= '0;
          end else if (REPEAT_EN && (r_cnt == c_DLY_LAST)) begin
            r_state  <= ST_REPEAT;
            r_cnt    <= '0;
            r_pulse  <= 1'b1;
            r_active <= 1'b1;
          end else if (REPEAT_EN) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!w_s) begin
            r_state  <= ST_REL_WAIT;
            r_cnt    <= '0;
            r_active <= 1'b0;
          end else if (r_cnt == c_PER_LAST) begin
            r_cnt   <= '0;
            r_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_REL_WAIT: begin
          // A bounce back to 1 re-arms the full repeat delay
          if (w_s) begin
            r_state <= ST_HELD;
            r_cnt   <= '0;
          end else if (r_cnt == c_DEB_LAST) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign btn_level     = r_level;
  assign btn_pulse     = r_pulse;
  assign btn_release   = r_release;
  assign repeat_active = r_active;

endmodule
`default_nettype wire
